// File: rtl/pll_lock_reset_seq.sv
// Lock-qualified reset sequencer: synchronizes pll_lock, qualifies it for a stable
// window, holds reset a little longer, then releases sys_rst_n for the PLL domain.
module pll_lock_reset_seq #(
   parameter int unsigned STABLE_CYCLES       = 1024,
   parameter int unsigned RESET_HOLD_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 2700000,
   parameter int unsigned LOSS_CNT_W          = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_lock,
   output logic                  sys_rst_n,
   output logic                  ready,
   output logic                  lock_lost,
   output logic                  timeout,
   output logic [LOSS_CNT_W-1:0] loss_count,
   output logic [1:0]            state
);

   localparam int unsigned MAX_SH = (STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                    STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int unsigned MAX_P  = (MAX_SH > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_SH : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0]      STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]      HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [LOSS_CNT_W-1:0] LOSS_MAX     = {LOSS_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                  cur;
   state_t                  nxt;
   logic                    s1;
   logic                    lock_s;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nx;
   logic                    timeout_nx;
   logic                    lost_nx;
   logic [LOSS_CNT_W-1:0]   loss_nx;

   // Two-flop synchronizer for the asynchronous lock indication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         s1     <= pll_lock;
         lock_s <= s1;
      end
   end

   // Next-state, shared counter and status next values
   always_comb begin
      nxt        = cur;
      cnt_nx     = cnt;
      timeout_nx = timeout;
      lost_nx    = 1'b0;
      loss_nx    = loss_count;
      case (cur)
         WAIT_LOCK: begin
            if (lock_s) begin
               nxt = STABILIZE;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         STABILIZE: begin
            if (!lock_s)                 nxt    = WAIT_LOCK;
            else if (cnt == STABLE_LAST) nxt    = HOLD;
            else                         cnt_nx = cnt + CNT_W'(1);
         end
         HOLD: begin
            if (!lock_s) begin
               nxt = WAIT_LOCK;
            end else if (cnt == HOLD_LAST) begin
               nxt        = RUN;
               timeout_nx = 1'b0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               nxt     = WAIT_LOCK;
               lost_nx = 1'b1;
               if (loss_count != LOSS_MAX) loss_nx = loss_count + LOSS_CNT_W'(1);
            end
         end
         default: nxt = WAIT_LOCK;
      endcase
      // Every state change restarts the shared counter
      if (nxt != cur) cnt_nx = '0;
   end

   // State and all outputs registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur        <= WAIT_LOCK;
         cnt        <= '0;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         timeout    <= 1'b0;
         loss_count <= '0;
      end else begin
         cur        <= nxt;
         cnt        <= cnt_nx;
         sys_rst_n  <= (nxt == RUN);
         ready      <= (nxt == RUN);
         lock_lost  <= lost_nx;
         timeout    <= timeout_nx;
         loss_count <= loss_nx;
      end
   end

   assign state = cur;

endmodule
